uart_rx_os16: RTL



---
 rtl/uart_rx_os16.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_os16.sv
// uart_rx_os16 - 16x oversampling UART receiver with valid/ready output.
// Resynchronises rx_i, validates the start bit, majority-votes samples
// 7/8/9 of every bit, deserialises 5..8 data bits plus optional parity and
// checks the stop bit. One character is held on the output until accepted.
// Optional feature macro: UART_RX_BREAK_DET_EN (break flag + BRK_WAIT state).
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | line idle, waiting for a synchronised falling edge
// S_START    | start bit; vote at sample 9 rejects glitches
// S_DATA     | data bits, LSB first, voted bit written at sample 9
// S_PARITY   | parity bit compared against the configured mode
// S_STOP     | stop bit; frame completes at sample 9, then back to IDLE
// S_BRK_WAIT | (break build only) wait for 16 consecutive high ticks
`timescale 1ns/1ps
module uart_rx_os16 #(
  parameter int SYNC_STAGES = 2,
  parameter int DIV_WIDTH   = 16
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 rx_i,
  input  logic                 cfg_en_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic                 cfg_parity_en_i,
  input  logic [1:0]           cfg_parity_sel_i,
  input  logic [1:0]           cfg_bits_i,
  output logic [7:0]           rx_data_o,
  output logic                 par_err_o,
  output logic                 frm_err_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 overrun_o,
  output logic                 busy_o,
  output logic                 break_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
`ifdef UART_RX_BREAK_DET_EN
    S_BRK_WAIT,
`endif
    S_STOP
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rx_prev;
  logic [DIV_WIDTH-1:0]   r_div_cnt;
  logic [3:0]             r_smp;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic                   r_v7;
  logic                   r_v8;
  logic                   r_par_err;
  logic [7:0]             r_data;
  logic                   r_par;
  logic                   r_frm;
  logic                   r_valid;
  logic                   r_overrun;
`ifdef UART_RX_BREAK_DET_EN
  logic                   r_par_bit;
  logic [3:0]             r_hi_cnt;
  logic                   r_break;
  logic                   w_brk;
`endif

  logic                   w_rx;
  logic                   w_start;
  logic                   w_tick;
  logic                   w_vote;
  logic                   w_par_exp;
  logic [2:0]             w_last;
  logic                   w_done;

  assign w_rx    = r_sync[SYNC_STAGES-1];
  assign w_start = (r_state == S_IDLE) && cfg_en_i && r_rx_prev && !w_rx;
  assign w_tick  = (r_div_cnt == cfg_div_i);
  // samples 7 and 8 are registered; sample 9 is the live synchronised line
  assign w_vote  = (r_v7 & r_v8) | (r_v7 & w_rx) | (r_v8 & w_rx);
  assign w_last  = {1'b0, cfg_bits_i} + 3'd4;
  assign w_done  = cfg_en_i && (r_state == S_STOP) && w_tick && (r_smp == 4'd9);

  // unused MSBs of r_shift are cleared at start, so a full 8-bit XOR is exact
  always_comb begin
    w_par_exp = 1'b0;
    case (cfg_parity_sel_i)
      2'b00:   w_par_exp = ^r_shift;
      2'b01:   w_par_exp = ~^r_shift;
      2'b10:   w_par_exp = 1'b0;
      default: w_par_exp = 1'b1;
    endcase
  end

`ifdef UART_RX_BREAK_DET_EN
  assign w_brk = (r_shift == 8'h00) && !(cfg_parity_en_i && r_par_bit) && !w_vote;
`endif

  // resynchronise the line and keep the previous value for edge detection
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_sync    <= '1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], rx_i};
      r_rx_prev <= w_rx;
    end
  end

  // oversample tick divider, re-phased to the start edge
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_div_cnt <= '0;
    end else if (w_start || w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // receive state machine: sample counting, voting and deserialisation
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_state   <= S_IDLE;
      r_smp     <= 4'd0;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
      r_v7      <= 1'b0;
      r_v8      <= 1'b0;
      r_par_err <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      r_par_bit <= 1'b0;
      r_hi_cnt  <= 4'd0;
`endif
    end else if (!cfg_en_i) begin
      r_state <= S_IDLE;
    end else if (r_state == S_IDLE) begin
      if (w_start) begin
        r_state   <= S_START;
        r_smp     <= 4'd0;
        r_bit_cnt <= 3'd0;
        r_shift   <= 8'h00;
        r_par_err <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        r_par_bit <= 1'b0;
`endif
      end
    end else if (w_tick) begin
      r_smp <= r_smp + 4'd1;
      if (r_smp == 4'd7) r_v7 <= w_rx;
      if (r_smp == 4'd8) r_v8 <= w_rx;
      case (r_state)
        S_START: begin
          if (r_smp == 4'd9 && w_vote) r_state <= S_IDLE;
          else if (r_smp == 4'd15)     r_state <= S_DATA;
        end
        S_DATA: begin
          if (r_smp == 4'd9) r_shift[r_bit_cnt] <= w_vote;
          if (r_smp == 4'd15) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == w_last) r_state <= cfg_parity_en_i ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (r_smp == 4'd9) begin
            r_par_err <= w_vote ^ w_par_exp;
`ifdef UART_RX_BREAK_DET_EN
            r_par_bit <= w_vote;
`endif
          end
          if (r_smp == 4'd15) r_state <= S_STOP;
        end
        S_STOP: begin
          if (r_smp == 4'd9) begin
`ifdef UART_RX_BREAK_DET_EN
            r_hi_cnt <= 4'd0;
            r_state  <= w_brk ? S_BRK_WAIT : S_IDLE;
`else
            r_state <= S_IDLE;
`endif
          end
        end
`ifdef UART_RX_BREAK_DET_EN
        S_BRK_WAIT: begin
          if (!w_rx)                  r_hi_cnt <= 4'd0;
          else if (r_hi_cnt == 4'd15) r_state  <= S_IDLE;
          else                        r_hi_cnt <= r_hi_cnt + 4'd1;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // output holding register, valid/ready handshake and overrun pulse
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_data    <= 8'h00;
      r_par     <= 1'b0;
      r_frm     <= 1'b0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      r_break   <= 1'b0;
`endif
    end else begin
      r_overrun <= 1'b0;
      if (w_done && (!r_valid || rx_ready_i)) begin
        r_data  <= r_shift;
        r_par   <= r_par_err;
        r_frm   <= ~w_vote;
        r_valid <= 1'b1;
`ifdef UART_RX_BREAK_DET_EN
        r_break <= w_brk;
`endif
      end else begin
        if (w_done)                r_overrun <= 1'b1;
        if (r_valid && rx_ready_i) r_valid   <= 1'b0;
      end
    end
  end

  assign rx_data_o  = r_data;
  assign par_err_o  = r_par;
  assign frm_err_o  = r_frm;
  assign rx_valid_o = r_valid;
  assign overrun_o  = r_overrun;
  assign busy_o     = (r_state != S_IDLE);
`ifdef UART_RX_BREAK_DET_EN
  assign break_o    = r_break;
`else
  assign break_o    = 1'b0;
`endif

endmodule
